// File: rtl/rr_arbiter_n_if.sv
// Request/grant bundle between N masters and one slave-port arbiter.
// The arbiter takes the slave modport; whoever drives requests takes the master modport.
interface rr_arbiter_n_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int IDX_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] req;
    logic                   ack;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   busy;
    logic                   timeout;

    modport master (output req, ack, input grant, grant_idx, busy, timeout);
    modport slave  (input req, ack, output grant, grant_idx, busy, timeout);
endinterface

// File: rtl/rr_arbiter_n.sv
// N-master round-robin arbiter with a registered one-hot grant and an encoded index.
// Define ARB_TIMEOUT_EN to add a grant watchdog that force-releases after TIMEOUT_CYCLES.
module rr_arbiter_n #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          reset,
    rr_arbiter_n_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("rr_arbiter_n: parameter out of range");
    end

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                 state_reg;
    logic [NUM_MASTERS-1:0] grant_reg;
    logic [IDX_W-1:0]       grant_idx_reg;
    logic [IDX_W-1:0]       last_reg;
    logic                   timeout_reg;

    logic                   owner_req;
    logic                   expire_now;
    logic                   release_now;
    logic [NUM_MASTERS-1:0] cand_req;
    logic [IDX_W-1:0]       start_idx;
    logic [IDX_W-1:0]       rot_idx [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] rot_req;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_found;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt_reg;
`endif

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_MASTERS - 1) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        owner_req  = |(bus.req & grant_reg);
        expire_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
        expire_now = (state_reg == OWNED) && !bus.ack && owner_req && (wd_cnt_reg == WD_LIMIT);
`endif
        release_now = (state_reg == OWNED) && (bus.ack || !owner_req || expire_now);
        // The releasing master is masked so it cannot win back the edge it lets go.
        cand_req  = release_now ? (bus.req & ~grant_reg) : bus.req;
        start_idx = next_idx(release_now ? grant_idx_reg : last_reg);
    end

    // Position gi of the rotated request vector is absolute index (start + gi) mod N.
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_rotate
        logic [IDX_W:0] sum;
        assign sum         = {1'b0, start_idx} + (IDX_W+1)'(gi);
        assign rot_idx[gi] = IDX_W'((sum >= (IDX_W+1)'(NUM_MASTERS)) ? sum - (IDX_W+1)'(NUM_MASTERS) : sum);
        assign rot_req[gi] = cand_req[rot_idx[gi]];
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                win_found = 1'b1;
                win_idx   = rot_idx[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            grant_idx_reg <= '0;
            last_reg      <= IDX_W'(NUM_MASTERS - 1);
            timeout_reg   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wd_cnt_reg    <= '0;
`endif
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        state_reg     <= OWNED;
                        grant_reg     <= NUM_MASTERS'(1) << win_idx;
                        grant_idx_reg <= win_idx;
`ifdef ARB_TIMEOUT_EN
                        wd_cnt_reg    <= '0;
`endif
                    end
                end
                OWNED: begin
                    if (release_now) begin
                        last_reg    <= grant_idx_reg;
                        timeout_reg <= expire_now;
`ifdef ARB_TIMEOUT_EN
                        wd_cnt_reg  <= '0;
`endif
                        if (win_found) begin
                            grant_reg     <= NUM_MASTERS'(1) << win_idx;
                            grant_idx_reg <= win_idx;
                        end else begin
                            state_reg     <= IDLE;
                            grant_reg     <= '0;
                            grant_idx_reg <= '0;
                        end
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        wd_cnt_reg <= wd_cnt_reg + 16'd1;
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant_reg;
    assign bus.grant_idx = grant_idx_reg;
    assign bus.busy      = |grant_reg;
    assign bus.timeout   = timeout_reg;
endmodule

// File: tb/tb_rr_arbiter_n.sv
// Randomised and directed bench for rr_arbiter_n with an ownership-level reference model.
// Define ARB_TIMEOUT_EN for both bench and RTL to cover the watchdog.
module tb_rr_arbiter_n;
    localparam int N  = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 1'b0;

    rr_arbiter_n_if #(.NUM_MASTERS(N)) bus ();

    rr_arbiter_n #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the slave, who released last, how long held.
    int owner   = -1;
    int last    = N - 1;
    int held    = 0;
    bit to_exp  = 1'b0;

    function automatic int pick(logic [N-1:0] r, int from, int mask);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (from + k) % N;
            if (i != mask && r[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        bit rel;
        bit expired;
        if (!reset) begin
            owner = -1; last = N - 1; held = 0; to_exp = 1'b0;
        end else if (owner < 0) begin
            to_exp = 1'b0;
            owner  = pick(bus.req, last, -1);
            held   = 0;
        end else begin
            rel     = bus.ack || !bus.req[owner];
            expired = 1'b0;
`ifdef ARB_TIMEOUT_EN
            if (!rel && held == TO - 1) expired = 1'b1;
`endif
            if (rel || expired) begin
                last   = owner;
                owner  = pick(bus.req, owner, owner);
                held   = 0;
                to_exp = expired;
            end else begin
                held++;
                to_exp = 1'b0;
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] eg;
            eg = (owner < 0) ? '0 : (N'(1) << owner);
            chk("model_grant", 32'(bus.grant), 32'(eg));
            chk("model_idx", 32'(bus.grant_idx), (owner < 0) ? 32'd0 : 32'(owner));
            chk("model_busy", 32'(bus.busy), 32'(owner >= 0));
            chk("model_timeout", 32'(bus.timeout), 32'(to_exp));
        end
    end

    // Drive at the current negedge, return at the next one with the result visible.
    task automatic cycle(logic [N-1:0] r, logic a);
        bus.req = r;
        bus.ack = a;
        @(negedge clk);
        $display("txn t=%0t reset=%0b req=%b ack=%0b -> grant=%b idx=%0d busy=%0b timeout=%0b",
                 $time, reset, r, a, bus.grant, bus.grant_idx, bus.busy, bus.timeout);
    endtask

    logic [N-1:0] rot_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        reset   = 1'b0;
        bus.req = '0;
        bus.ack = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        cycle(4'b0000, 1'b0);
        chk("reset_grant", 32'(bus.grant), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;

        // Two requesters alternate on ack with no idle gap.
        cycle(4'b0101, 1'b0); chk("two_first", 32'(bus.grant), 32'b0001);
        cycle(4'b0101, 1'b1); chk("two_ack1", 32'(bus.grant), 32'b0100);
        cycle(4'b0101, 1'b1); chk("two_ack2", 32'(bus.grant), 32'b0001);
        cycle(4'b0101, 1'b1); chk("two_ack3", 32'(bus.grant), 32'b0100);
        // Master 2 withdraws, master 3 takes over immediately.
        cycle(4'b1000, 1'b0);
        chk("withdraw_grant", 32'(bus.grant), 32'b1000);
        chk("withdraw_idx", 32'(bus.grant_idx), 32'd3);
        chk("withdraw_timeout", 32'(bus.timeout), 32'd0);

        // Full contention rotates through every master.
        reset = 1'b0; cycle(4'b0000, 1'b0); reset = 1'b1;
        cycle(4'b1111, 1'b0); chk("rot_start", 32'(bus.grant), 32'b0001);
        for (int k = 0; k < 4; k++) begin
            cycle(4'b1111, 1'b0);
            cycle(4'b1111, 1'b0);
            cycle(4'b1111, 1'b1);
            chk($sformatf("rot_%0d", k), 32'(bus.grant), 32'(rot_seq[k]));
        end

        // Single requester: one idle cycle after release, ack while idle ignored.
        reset = 1'b0; cycle(4'b0000, 1'b0); reset = 1'b1;
        cycle(4'b0001, 1'b0); chk("single_grant", 32'(bus.grant), 32'b0001);
        for (int k = 0; k < 3; k++) cycle(4'b0001, 1'b0);
        cycle(4'b0001, 1'b1); chk("single_idle", 32'(bus.grant), 32'd0);
        cycle(4'b0001, 1'b0); chk("single_regrant", 32'(bus.grant), 32'b0001);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        chk("ack_idle_grant", 32'(bus.grant), 32'd0);
        chk("ack_idle_busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of an ownership.
        cycle(4'b0100, 1'b0); chk("mid_grant", 32'(bus.grant), 32'b0100);
        reset = 1'b0;
        cycle(4'b0100, 1'b0);
        chk("mid_reset_grant", 32'(bus.grant), 32'd0);
        chk("mid_reset_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        cycle(4'b1111, 1'b0); chk("post_reset", 32'(bus.grant), 32'b0001);

`ifdef ARB_TIMEOUT_EN
        reset = 1'b0; cycle(4'b0000, 1'b0); reset = 1'b1;
        cycle(4'b0011, 1'b0); chk("wd_first", 32'(bus.grant), 32'b0001);
        for (int k = 0; k < TO - 1; k++) begin
            cycle(4'b0011, 1'b0);
            chk("wd_hold", 32'(bus.grant), 32'b0001);
        end
        cycle(4'b0011, 1'b0);
        chk("wd_expire_grant", 32'(bus.grant), 32'b0010);
        chk("wd_expire_pulse", 32'(bus.timeout), 32'd1);
        for (int k = 0; k < TO - 1; k++) cycle(4'b0011, 1'b0);
        cycle(4'b0011, 1'b1);
        chk("wd_ack_grant", 32'(bus.grant), 32'b0001);
        chk("wd_ack_pulse", 32'(bus.timeout), 32'd0);
`endif

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] r;
            r = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : bus.req;
            reset = ($urandom_range(0, 99) != 0);
            cycle(r, ($urandom_range(0, 3) == 0));
        end
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_arbiter_n.md
Name: rr_arbiter_n

Overview:
- N-master round-robin arbiter, one instance per slave port of the crossbar.
- Grants one master at a time and holds the grant until the slave acks or the master withdraws its request.
- Rotates priority on every release, so no master starves under contention.
- Registered one-hot grant plus encoded index drive the crossbar's slave-side mux select.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (legal range 2..16).
- TIMEOUT_CYCLES, 64, grant watchdog limit in cycles; used only when ARB_TIMEOUT_EN is defined (legal range 1..65535).
- IDX_W, $clog2(NUM_MASTERS), localparam, width of grant_idx.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req  input  NUM_MASTERS  request per master; bit i = master i.
- ack  input  1  slave completion strobe for the current grant; one cycle.
- grant  output  NUM_MASTERS  registered one-hot grant; all zero when idle.
- grant_idx  output  IDX_W  index of the granted master; 0 when idle.
- busy  output  1  high while any grant bit is set.
- timeout  output  1  one-cycle pulse on a watchdog release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (reset==0 at a clk edge):
  - grant=0, grant_idx=0, busy=0, timeout=0.
  - Priority pointer last=NUM_MASTERS-1, so master 0 has highest priority first.
  - Watchdog counter=0.
- States: IDLE (grant==0) and OWNED (exactly one grant bit set). grant is never multi-hot.
- Arbitration function: search req starting at index (last+1) mod N, ascending with wrap-around; the first set bit wins.
- IDLE:
  - req==0: stay IDLE.
  - Otherwise: next edge enters OWNED with grant=onehot(winner) and grant_idx=winner.
  - Latency from req to grant: 1 cycle.
  - last is not updated on grant.
- OWNED by master g, evaluated each edge in this priority order:
  1. ack==1 → release g; set last=g; re-arbitrate among req with bit g masked in that same edge. If another master is requesting, the grant moves to it with no idle cycle; otherwise go to IDLE.
  2. req[g]==0 (withdrawal without ack) → same release and re-arbitration as ack.
  3. Otherwise hold grant, and grant_idx stays stable.
- Simultaneous ack and req[g] drop: treated as a single ack release.
- ack while IDLE: ignored, no state change.
- A master that re-requests right after release is not re-granted while any other master requests (it is masked for that edge, and last=g places it lowest next time).
- Single requester: after a release with no other requester, the next grant goes back to the same master after one IDLE cycle, latency 1 as above.
- busy is the reduction-OR of grant, derived from registers.
- Reset mid-OWNED: grant drops at that edge, pointer returns to N-1, and no ack is pending afterwards.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on every entry to OWNED and increments each cycle the grant is held without ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack or withdrawal, the next edge releases g exactly as for an ack (last=g, re-arbitrate) and pulses timeout=1 for one cycle.
  - An ack arriving on the same edge as expiry takes precedence, and timeout stays 0.
- Not defined: no counter; timeout is tied to 0; a grant is held indefinitely until ack or withdrawal.

Test Plan:
- Reset, then N=4 and req=4'b0101 held → grant=0001 one cycle later; ack → grant=0100 the next edge, no idle cycle; ack → grant=0001.
- req=4'b1111 held, ack every 3rd cycle → grant sequence 0001,0010,0100,1000,0001; each master granted once per 4 acks.
- Master 2 granted, req[2] drops without ack, req[3]=1 → next edge grant=1000; timeout stays 0.
- req=0001 only; ack at cycle 5 → IDLE for one cycle, then grant=0001 again; ack while IDLE → no change.
- Reset driven low mid-grant (grant=0100) → grant=0, busy=0 at that edge; after reset release with req=1111 → grant=0001.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, req=0011, no ack → grant=0001 for 8 cycles, then grant=0010 with a one-cycle timeout pulse; ack on the expiry edge → timeout=0.
